// File: rtl/sw_event_generator.sv
// Turns a debounced key level into single-cycle press/release/long-press/repeat events.
// States: IDLE = key up | PRESSED = held, timing to long-press | LONG = held past threshold, auto-repeating
module sw_event_generator #(
  parameter int HOLD_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic CleanSWIn,
  output logic PressPulse,
  output logic ReleasePulse,
  output logic LongPress,
  output logic RepeatPulse,
  output logic Held
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sw_prev_q;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;
  logic             rise;

  assign rise = CleanSWIn & ~sw_prev_q;

  // sw_prev resets high so a key held across reset must be released before it can press.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sw_prev_q <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sw_prev_q <= CleanSWIn;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    held_d    = held_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESSED;
          cnt_d   = CNT_ONE;
          press_d = 1'b1;
          held_d  = 1'b1;
        end
      end
      PRESSED: begin
        // Release wins over a threshold hit on the same edge.
        if (!CleanSWIn) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          held_d    = 1'b0;
        end else if (cnt_q == HOLD_TC) begin
          state_d = LONG;
          cnt_d   = CNT_ONE;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      LONG: begin
        if (!CleanSWIn) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          held_d    = 1'b0;
        end else if (cnt_q == REPEAT_TC) begin
          cnt_d    = CNT_ONE;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        held_d  = 1'b0;
      end
    endcase
  end

  assign PressPulse   = press_q;
  assign ReleasePulse = release_q;
  assign LongPress    = long_q;
  assign RepeatPulse  = repeat_q;
  assign Held         = held_q;

endmodule

// File: tb/tb_sw_event_generator.sv
// Directed bench for sw_event_generator: per-cycle vector table plus an async reset-in-LONG sequence.
module tb_sw_event_generator;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic CleanSWIn = 1'b0;
  logic PressPulse, ReleasePulse, LongPress, RepeatPulse, Held;

  int checks = 0;
  int failures = 0;

  // expected bit order: {press, release, long, repeat, held}
  typedef struct {
    logic       rst;
    logic       sw;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  sw_event_generator #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .CleanSWIn(CleanSWIn),
    .PressPulse(PressPulse),
    .ReleasePulse(ReleasePulse),
    .LongPress(LongPress),
    .RepeatPulse(RepeatPulse),
    .Held(Held)
  );

  always #5 CLK = ~CLK;

  function automatic void add(input logic rst, input logic sw, input logic [4:0] exp, input int n = 1);
    vec_t v;
    v.rst = rst;
    v.sw  = sw;
    v.exp = exp;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  function automatic logic [4:0] outs();
    return {PressPulse, ReleasePulse, LongPress, RepeatPulse, Held};
  endfunction

  task automatic compare(input string name, input logic [4:0] exp);
    logic [4:0] got;
    logic [3:0] pulses;
    got = outs();
    pulses = got[4:1];
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got outputs=%b expected=%b at t=%0t", name, got, exp, $time);
    end
    checks++;
    if ($countones(pulses) > 1) begin
      failures++;
      $display("FAIL %s exclusivity: got pulses=%b expected at most one high at t=%0t", name, pulses, $time);
    end
  endtask

  task automatic step(input logic rst, input logic sw, input logic [4:0] exp, input string name);
    @(negedge CLK);
    RST = rst;
    CleanSWIn = sw;
    @(posedge CLK);
    #1;
    compare(name, exp);
  endtask

  initial begin
    // reset then idle
    add(1, 0, 5'b00000, 3);
    add(0, 0, 5'b00000, 20);
    // short press, 5 cycles
    add(0, 1, 5'b10001);
    add(0, 1, 5'b00001, 4);
    add(0, 0, 5'b01000);
    add(0, 0, 5'b00000, 3);
    // long press with repeat, 25 cycles
    for (int k = 0; k < 25; k++) begin
      if (k == 0)                         add(0, 1, 5'b10001);
      else if (k == 8)                    add(0, 1, 5'b00101);
      else if (k >= 12 && (k % 4) == 0)   add(0, 1, 5'b00011);
      else                                add(0, 1, 5'b00001);
    end
    add(0, 0, 5'b01000);
    add(0, 0, 5'b00000, 2);
    // release on the hold threshold edge
    add(0, 1, 5'b10001);
    add(0, 1, 5'b00001, 7);
    add(0, 0, 5'b01000);
    add(0, 0, 5'b00000, 2);
    // minimum press and immediate re-press
    add(0, 1, 5'b10001);
    add(0, 0, 5'b01000);
    add(0, 1, 5'b10001);
    add(0, 0, 5'b01000);
    add(0, 0, 5'b00000, 2);
    // key held through reset
    add(1, 1, 5'b00000, 2);
    add(0, 1, 5'b00000, 15);
    add(0, 0, 5'b00000);
    add(0, 1, 5'b10001);
    add(0, 0, 5'b01000);
    add(0, 0, 5'b00000, 2);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].rst, vecs[i].sw, vecs[i].exp, $sformatf("vec%0d", i));

    // async reset while in LONG
    step(0, 1, 5'b10001, "midlong_press");
    for (int k = 1; k <= 14; k++) begin
      if (k == 8)       step(0, 1, 5'b00101, "midlong_long");
      else if (k == 12) step(0, 1, 5'b00011, "midlong_repeat");
      else              step(0, 1, 5'b00001, $sformatf("midlong_hold%0d", k));
    end
    RST = 1'b1;
    #1;
    compare("midlong_async_rst", 5'b00000);
    step(1, 1, 5'b00000, "midlong_rst_hold");
    for (int k = 0; k < 10; k++) step(0, 1, 5'b00000, $sformatf("midlong_after%0d", k));
    step(0, 0, 5'b00000, "midlong_let_go");
    step(0, 1, 5'b10001, "midlong_repress");
    step(0, 0, 5'b01000, "midlong_rerelease");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
